// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the CPU execution controller.
package run_ctrl_pkg;

    localparam int unsigned PC_W_DEFAULT    = 16;
    localparam int unsigned CNT_W_DEFAULT   = 16;
    localparam int unsigned BURST_W_DEFAULT = 8;
    localparam int unsigned SYNC_STAGES     = 2;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2,
        BREAK = 2'd3
    } run_state_e;

endpackage

// File: rtl/sync_edge.sv
// N-flop synchroniser with a registered rising-edge pulse and a level output.
module sync_edge
    import run_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] fill_q;
    logic              prev_q;
    logic              rise_q;

    // prev_q holds 1 until the chain carries real samples, so a level already
    // high when reset releases is never seen as a new press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            fill_q <= '0;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            fill_q <= {fill_q[STAGES-2:0], 1'b1};
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            prev_q <= fill_q[STAGES-1] ? sync_q[STAGES-1] : 1'b1;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;

endmodule

// File: rtl/run_ctrl.sv
// Execution controller: free-run, burst step and PC breakpoint, issuing a
// one-cycle cpu_en advance pulse per qualifying tick.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned BURST_W = BURST_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               step_in,
    input  logic               run_in,
    input  logic [BURST_W-1:0] burst_n,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    pc,
    output logic               cpu_en,
    output logic               halted,
    output logic               at_break,
    output logic [CNT_W-1:0]   cycles
);

    logic step_evt;
    logic run_s;
    logic unused_step_lvl;
    logic unused_run_rise;

    sync_edge #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clock (clock),
        .reset (reset),
        .d     (step_in),
        .level (unused_step_lvl),
        .rise  (step_evt)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_run_sync (
        .clock (clock),
        .reset (reset),
        .d     (run_in),
        .level (run_s),
        .rise  (unused_run_rise)
    );

    run_state_e         state_q, state_d;
    logic [BURST_W-1:0] remain_q, remain_d;
    logic [BURST_W-1:0] load_val;
    logic               skip_q, skip_d;
    logic               arm_q, arm_d;
    logic               cpu_en_d;
    logic               halted_d;
    logic               at_break_d;
    logic [CNT_W-1:0]   cycles_d;
    logic               bp_hit;

    assign load_val = (burst_n == '0) ? BURST_W'(1) : burst_n;

    // pc is stale while a pulse is in flight, so the compare is masked then.
    assign bp_hit = bp_en && (pc == bp_addr) && !skip_q && !cpu_en;

    // Next-state and registered-output logic; arm_q requires run to drop
    // after a breakpoint before RUN may be re-entered.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        skip_d     = skip_q;
        arm_d      = arm_q | ~run_s;
        cpu_en_d   = 1'b0;
        case (state_q)
            HALT: begin
                if (run_s && arm_q) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                end else if (step_evt) begin
                    state_d  = BURST;
                    remain_d = load_val;
                end
            end
            RUN: begin
                if (!run_s) begin
                    state_d = HALT;
                end else if (bp_hit) begin
                    state_d = BREAK;
                    arm_d   = 1'b0;
                end else if (tick) begin
                    cpu_en_d = 1'b1;
                    skip_d   = 1'b0;
                end
            end
            BURST: begin
                if (tick) begin
                    cpu_en_d = 1'b1;
                    remain_d = remain_q - BURST_W'(1);
                    if (remain_q <= BURST_W'(1)) begin
                        if (run_s && arm_q) begin
                            state_d = RUN;
                            skip_d  = 1'b1;
                        end else begin
                            state_d = HALT;
                        end
                    end
                end
            end
            BREAK: begin
                if (step_evt) begin
                    state_d  = BURST;
                    remain_d = load_val;
                end else if (!run_s) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
        cycles_d   = cycles + CNT_W'(cpu_en_d);
        halted_d   = (state_d == HALT) || (state_d == BREAK);
        at_break_d = (state_d == BREAK);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= HALT;
            remain_q <= '0;
            skip_q   <= 1'b0;
            arm_q    <= 1'b1;
            cpu_en   <= 1'b0;
            halted   <= 1'b1;
            at_break <= 1'b0;
            cycles   <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            skip_q   <= skip_d;
            arm_q    <= arm_d;
            cpu_en   <= cpu_en_d;
            halted   <= halted_d;
            at_break <= at_break_d;
            cycles   <= cycles_d;
        end
    end

endmodule
